// File: rtl/matrix_loader.sv
// matrix_loader: receives a stream of signed words and stores matrix A
// (M x K, row-major) followed by matrix B (K x N, row-major). The held
// matrices stay readable until a consumer releases them with compute_finished.
// A set may skip A (new_A = 0) so that the A already held is reused with a
// new B and the previously captured K.
//
// Handshake: a word moves on a rising edge where AXIS_TVALID and AXIS_TREADY
// are both 1. AXIS_TREADY is high only while a set is being loaded; the
// upstream may hold TVALID low for any number of cycles.
module matrix_loader #(
  parameter int INW  = 12,
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS = $clog2(MAXK + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INW-1:0]              AXIS_TDATA,
  input  logic                        AXIS_TVALID,
  input  logic [K_BITS:0]             AXIS_TUSER,
  output logic                        AXIS_TREADY,
  output logic                        matrices_loaded,
  input  logic                        compute_finished,
  output logic [K_BITS-1:0]           K,
  input  logic [$clog2(M*MAXK)-1:0]   A_read_addr,
  output logic [INW-1:0]              A_data,
  input  logic [$clog2(MAXK*N)-1:0]   B_read_addr,
  output logic [INW-1:0]              B_data
);

  localparam int A_DEPTH = M * MAXK;
  localparam int B_DEPTH = MAXK * N;
  localparam int A_AW    = $clog2(A_DEPTH);
  localparam int B_AW    = $clog2(B_DEPTH);
  localparam int CW      = $clog2(((A_DEPTH > B_DEPTH) ? A_DEPTH : B_DEPTH) + 1);
  localparam logic [A_AW-1:0] A_LAST = A_AW'(A_DEPTH - 1);
  localparam logic [B_AW-1:0] B_LAST = B_AW'(B_DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     wr_cnt, wr_cnt_nxt;
  logic [K_BITS-1:0] k_reg, k_nxt, k_sel;
  logic              a_valid, a_valid_nxt;
  logic              out_en;
  logic              xfer;
  logic              first_word;
  logic              new_a;
  logic              a_we, b_we;
  logic [A_AW-1:0]   a_wa;
  logic [B_AW-1:0]   b_wa;
  logic [CW-1:0]     a_len, b_len;

  logic [INW-1:0]    a_mem [A_DEPTH];
  logic [INW-1:0]    b_mem [B_DEPTH];

  assign xfer       = AXIS_TVALID && AXIS_TREADY;
  assign first_word = (state == LOAD_A) && (wr_cnt == '0);
  // Until a complete A has been stored, a set cannot skip A.
  assign new_a      = AXIS_TUSER[0] || !a_valid;
  // The K field only matters on the first word of a set that loads A.
  assign k_sel      = (first_word && new_a) ? AXIS_TUSER[K_BITS:1] : k_reg;
  assign a_len      = CW'(M) * CW'(k_sel);
  assign b_len      = CW'(k_sel) * CW'(N);
  assign K          = k_reg;

  // State, counter, K and A-valid registers; out_en keeps TREADY low until
  // the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LOAD_A;
      wr_cnt  <= '0;
      k_reg   <= '0;
      a_valid <= 1'b0;
      out_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_cnt  <= wr_cnt_nxt;
      k_reg   <= k_nxt;
      a_valid <= a_valid_nxt;
      out_en  <= 1'b1;
    end
  end

  // Next-state, write-counter and memory write-enable decode.
  always_comb begin
    state_nxt   = state;
    wr_cnt_nxt  = wr_cnt;
    k_nxt       = k_reg;
    a_valid_nxt = a_valid;
    a_we        = 1'b0;
    b_we        = 1'b0;
    a_wa        = A_AW'(wr_cnt);
    b_wa        = B_AW'(wr_cnt);
    unique case (state)
      LOAD_A: begin
        if (xfer) begin
          if (first_word && !new_a) begin
            // Reuse the held A: this word is B[0] and K is kept.
            b_we = 1'b1;
            b_wa = '0;
            if (b_len == CW'(1)) begin
              state_nxt  = READY;
              wr_cnt_nxt = '0;
            end else begin
              state_nxt  = LOAD_B;
              wr_cnt_nxt = CW'(1);
            end
          end else begin
            a_we = 1'b1;
            if (first_word) begin
              k_nxt = AXIS_TUSER[K_BITS:1];
            end
            if (wr_cnt == a_len - CW'(1)) begin
              state_nxt   = LOAD_B;
              wr_cnt_nxt  = '0;
              a_valid_nxt = 1'b1;
            end else begin
              wr_cnt_nxt = wr_cnt + CW'(1);
            end
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          b_we = 1'b1;
          if (wr_cnt == b_len - CW'(1)) begin
            state_nxt  = READY;
            wr_cnt_nxt = '0;
          end else begin
            wr_cnt_nxt = wr_cnt + CW'(1);
          end
        end
      end
      READY: begin
        if (compute_finished) begin
          state_nxt = LOAD_A;
        end
      end
      default: begin
        state_nxt  = LOAD_A;
        wr_cnt_nxt = '0;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    AXIS_TREADY     = out_en && (state != READY);
    matrices_loaded = (state == READY);
  end

  // Matrix storage writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (a_we) begin
      a_mem[a_wa] <= AXIS_TDATA;
    end
    if (b_we) begin
      b_mem[b_wa] <= AXIS_TDATA;
    end
  end

  // Registered read ports, one-cycle latency, usable in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A_data <= '0;
      B_data <= '0;
    end else begin
      A_data <= (A_read_addr <= A_LAST) ? a_mem[A_read_addr] : '0;
      B_data <= (B_read_addr <= B_LAST) ? b_mem[B_read_addr] : '0;
    end
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter INW, default 12, meaning element width in bits (signed).
REQ-002 SHALL have parameter M, default 7, meaning rows of A.
REQ-003 SHALL have parameter N, default 9, meaning columns of B.
REQ-004 SHALL have parameter MAXK, default 8, meaning maximum inner dimension K.
REQ-005 SHALL have localparam K_BITS = $clog2(MAXK+1).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port AXIS_TDATA, input, INW, the stream data word.
REQ-009 SHALL have port AXIS_TVALID, input, 1, meaning the upstream word is valid.
REQ-010 SHALL have port AXIS_TUSER, input, K_BITS+1; [K_BITS:1] = K, [0] = new_A.
REQ-011 SHALL have port AXIS_TREADY, output, 1, meaning the block accepts a word.
REQ-012 SHALL have port matrices_loaded, output, 1, meaning A and B are complete and readable.
REQ-013 SHALL have port compute_finished, input, 1, a consumer pulse that releases the matrices.
REQ-014 SHALL have port K, output, K_BITS, the inner dimension of the held matrices.
REQ-015 SHALL have port A_read_addr, input, $clog2(M*MAXK), the A row-major read address.
REQ-016 SHALL have port A_data, output, INW, the A read data.
REQ-017 SHALL have port B_read_addr, input, $clog2(MAXK*N), the B row-major read address.
REQ-018 SHALL have port B_data, output, INW, the B read data.

Function
REQ-019 SHALL implement FSM states LOAD_A, LOAD_B, READY; a transfer is one cycle with TVALID=1 and TREADY=1.
REQ-020 SHALL drive AXIS_TREADY=1 in LOAD_A and LOAD_B and 0 in READY.
REQ-021 SHALL, in LOAD_A on the first transfer of a set (write counter 0), capture K from TUSER[K_BITS:1] and branch on TUSER[0]: 1 -> load A; 0 -> skip A, write this word as B[0], go to LOAD_B, retain the stored K, and ignore the TUSER K field.
REQ-022 SHALL treat new_A as 1 for the first set after reset, because A is then invalid.
REQ-023 SHALL store A words at addresses 0..M*K-1 in arrival order and then enter LOAD_B on the cycle after transfer M*K-1.
REQ-024 SHALL store B words at addresses 0..K*N-1 in arrival order and then enter READY on the cycle after transfer K*N-1.
REQ-025 SHALL ignore TUSER on every transfer except the first of a set.
REQ-026 SHALL advance no counter or memory while TVALID=0; gaps of any length are legal.
REQ-027 SHALL drive matrices_loaded=1 exactly while in READY.
REQ-028 SHALL go from READY to LOAD_A on the edge where compute_finished=1 and SHALL ignore compute_finished in the other states.
REQ-029 SHALL hold the K output stable from capture until the next capture.
REQ-030 SHALL give synchronous reads with one-cycle latency: A_data/B_data at cycle t+1 equal the memory at the address presented at t, in every state.
REQ-031 SHALL support K only in 1..MAXK; other K values are out of contract.
REQ-032 SHALL leave memory contents uninitialised; they are valid only under matrices_loaded=1.

Reset
REQ-033 SHALL, while reset is asserted, force the state to LOAD_A, clear the write counters, set matrices_loaded=0, AXIS_TREADY=0, K=0, A_data=0 and B_data=0, and mark A invalid.
REQ-034 SHALL, on reset mid-load, discard the partial set; after release it SHALL accept a fresh set, with AXIS_TREADY=1 from the first edge after deassertion.

Verification
REQ-035 SHALL pass this scenario: reset, then a stream with K=3 and new_A=1, A = 1..21, B = 101..127 -> TREADY drops after 48 transfers, matrices_loaded=1, K=3, read A[20]=21 and B[0]=101 one cycle after the address.
REQ-036 SHALL pass this scenario: the same load with TVALID toggled 1,0,0,1 randomly -> identical memory contents and identical matrices_loaded assertion after transfer 48.
REQ-037 SHALL pass this scenario: compute_finished pulse, then a set with new_A=0, TUSER K=5, and 27 B words 200..226 -> K stays 3, A is unchanged (A[0]=1), B[26]=226, matrices_loaded after 27 transfers.
REQ-038 SHALL pass this scenario: new_A=0 on the first set after reset with K=2 -> the block still loads 14 A words then 18 B words.
REQ-039 SHALL pass this scenario: reset asserted mid-clock after 10 A words -> matrices_loaded=0 and TREADY=0 immediately; a full K=1 set (7+9 words) afterwards loads correctly.
REQ-040 SHALL pass this scenario: compute_finished pulsed during LOAD_B -> no effect, and matrices_loaded still asserts after the last B word.
